// File: rtl/ext_search_ctrl.sv
// ext_search_ctrl: streams CHUNKS chunks of CHUNK lanes from a chunk memory,
// reduces each chunk to its extreme (min or max by COMPARATOR) and keeps the
// running best with its chunk index. Ties always keep the earlier element.
// Optional: define EXT_SEARCH_INDEX_EN to add res_idx, the global element
// index (res_chunk*CHUNK + winning lane).
module ext_search_ctrl #(
  parameter int LEVEL      = 4,
  parameter int DATA_SZ    = 4,
  parameter int CHUNKS     = 4,
  parameter int COMPARATOR = 0
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic                                     start_valid,
  output logic                                     start_ready,
  output logic                                     rd_en,
  output logic [$clog2(CHUNKS)-1:0]                rd_addr,
  input  logic [(2**(LEVEL-1))*DATA_SZ-1:0]        rd_data,
  output logic                                     res_valid,
  input  logic                                     res_ready,
  output logic [DATA_SZ-1:0]                       res_value,
`ifdef EXT_SEARCH_INDEX_EN
  output logic [$clog2(CHUNKS)-1:0]                res_chunk,
  output logic [$clog2(CHUNKS)+LEVEL-2:0]          res_idx
`else
  output logic [$clog2(CHUNKS)-1:0]                res_chunk
`endif
);

  localparam int CHUNK = 2**(LEVEL-1);
  localparam int AW    = $clog2(CHUNKS);
  localparam int LW    = LEVEL-1;

  typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [AW-1:0]       cnt_q, cnt_d;
  logic                pend_q;
  logic [AW-1:0]       pend_addr_q;
  logic                best_vld_q, best_vld_d;
  logic [DATA_SZ-1:0]  best_val_q, best_val_d;
  logic [AW-1:0]       best_chunk_q, best_chunk_d;
  logic [DATA_SZ-1:0]  chunk_val;
`ifdef EXT_SEARCH_INDEX_EN
  logic [LW-1:0]       best_lane_q, best_lane_d;
  logic [LW-1:0]       chunk_lane;
`endif

  function automatic logic better(input logic [DATA_SZ-1:0] a,
                                  input logic [DATA_SZ-1:0] b);
    if (COMPARATOR != 0) return a > b;
    else                 return a < b;
  endfunction

  // Binary reduction tree over the lanes; a higher lane replaces a lower one
  // only when strictly better, so the lowest lane wins ties.
  always_comb begin
    logic [DATA_SZ-1:0] tv [CHUNK];
`ifdef EXT_SEARCH_INDEX_EN
    logic [LW-1:0]      ti [CHUNK];
`endif
    for (int unsigned k = 0; k < CHUNK; k++) begin
      tv[k] = rd_data[k*DATA_SZ +: DATA_SZ];
`ifdef EXT_SEARCH_INDEX_EN
      ti[k] = LW'(k);
`endif
    end
    for (int unsigned l = 0; l < LW; l++) begin
      for (int unsigned i = 0; i < CHUNK; i += (2 << l)) begin
        if (better(tv[i + (1 << l)], tv[i])) begin
          tv[i] = tv[i + (1 << l)];
`ifdef EXT_SEARCH_INDEX_EN
          ti[i] = ti[i + (1 << l)];
`endif
        end
      end
    end
    chunk_val = tv[0];
`ifdef EXT_SEARCH_INDEX_EN
    chunk_lane = ti[0];
`endif
  end

  // State and datapath registers; reset abandons any in-flight search.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      pend_q       <= 1'b0;
      pend_addr_q  <= '0;
      best_vld_q   <= 1'b0;
      best_val_q   <= '0;
      best_chunk_q <= '0;
`ifdef EXT_SEARCH_INDEX_EN
      best_lane_q  <= '0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      pend_q       <= rd_en;
      pend_addr_q  <= rd_addr;
      best_vld_q   <= best_vld_d;
      best_val_q   <= best_val_d;
      best_chunk_q <= best_chunk_d;
`ifdef EXT_SEARCH_INDEX_EN
      best_lane_q  <= best_lane_d;
`endif
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start_valid) state_d = S_READ;
      S_READ:  if (cnt_q == AW'(CHUNKS-1)) state_d = S_DRAIN;
      S_DRAIN: state_d = S_DONE;
      S_DONE:  if (res_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Read counter and running-best update; data lags its rd_en by one cycle.
  always_comb begin
    cnt_d        = cnt_q;
    best_vld_d   = best_vld_q;
    best_val_d   = best_val_q;
    best_chunk_d = best_chunk_q;
`ifdef EXT_SEARCH_INDEX_EN
    best_lane_d  = best_lane_q;
`endif
    if (state_q == S_IDLE && start_valid) begin
      cnt_d        = '0;
      best_vld_d   = 1'b0;
      best_val_d   = '0;
      best_chunk_d = '0;
`ifdef EXT_SEARCH_INDEX_EN
      best_lane_d  = '0;
`endif
    end
    if (state_q == S_READ) cnt_d = cnt_q + 1'b1;
    if (pend_q && (state_q == S_READ || state_q == S_DRAIN) &&
        (!best_vld_q || better(chunk_val, best_val_q))) begin
      best_vld_d   = 1'b1;
      best_val_d   = chunk_val;
      best_chunk_d = pend_addr_q;
`ifdef EXT_SEARCH_INDEX_EN
      best_lane_d  = chunk_lane;
`endif
    end
  end

  // State-decoded outputs.
  always_comb begin
    start_ready = (state_q == S_IDLE);
    rd_en       = (state_q == S_READ);
    rd_addr     = (state_q == S_READ) ? cnt_q : '0;
    res_valid   = (state_q == S_DONE);
  end

  assign res_value = best_val_q;
  assign res_chunk = best_chunk_q;
`ifdef EXT_SEARCH_INDEX_EN
  assign res_idx   = {best_chunk_q, best_lane_q};
`endif

endmodule

// File: tb/tb_ext_search_ctrl.sv
// Bench for ext_search_ctrl: a min-mode and a max-mode instance see the same
// chunk memory contents; results are checked against a linear first-occurrence
// scan of the whole memory. res_idx is checked when EXT_SEARCH_INDEX_EN is set.
module tb_ext_search_ctrl;

  localparam int LEVEL   = 4;
  localparam int DATA_SZ = 4;
  localparam int CHUNKS  = 4;
  localparam int CHUNK   = 2**(LEVEL-1);
  localparam int AW      = $clog2(CHUNKS);
  localparam int N       = CHUNKS*CHUNK;

  logic clk = 1'b0;
  logic rst;
  logic start_valid;
  logic res_ready;

  logic                       start_ready [2];
  logic                       rd_en       [2];
  logic [AW-1:0]              rd_addr     [2];
  logic [CHUNK*DATA_SZ-1:0]   rd_data     [2];
  logic                       res_valid   [2];
  logic [DATA_SZ-1:0]         res_value   [2];
  logic [AW-1:0]              res_chunk   [2];
`ifdef EXT_SEARCH_INDEX_EN
  logic [AW+LEVEL-2:0]        res_idx     [2];
`endif

  logic [DATA_SZ-1:0] mem [N];
  logic [DATA_SZ-1:0] exp_val [2];
  int                 exp_pos [2];

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ext_search_ctrl #(.LEVEL(LEVEL), .DATA_SZ(DATA_SZ), .CHUNKS(CHUNKS), .COMPARATOR(0)) u_min (
    .clk(clk), .rst(rst), .start_valid(start_valid), .start_ready(start_ready[0]),
    .rd_en(rd_en[0]), .rd_addr(rd_addr[0]), .rd_data(rd_data[0]),
    .res_valid(res_valid[0]), .res_ready(res_ready), .res_value(res_value[0]),
`ifdef EXT_SEARCH_INDEX_EN
    .res_chunk(res_chunk[0]), .res_idx(res_idx[0])
`else
    .res_chunk(res_chunk[0])
`endif
  );

  ext_search_ctrl #(.LEVEL(LEVEL), .DATA_SZ(DATA_SZ), .CHUNKS(CHUNKS), .COMPARATOR(1)) u_max (
    .clk(clk), .rst(rst), .start_valid(start_valid), .start_ready(start_ready[1]),
    .rd_en(rd_en[1]), .rd_addr(rd_addr[1]), .rd_data(rd_data[1]),
    .res_valid(res_valid[1]), .res_ready(res_ready), .res_value(res_value[1]),
`ifdef EXT_SEARCH_INDEX_EN
    .res_chunk(res_chunk[1]), .res_idx(res_idx[1])
`else
    .res_chunk(res_chunk[1])
`endif
  );

  function automatic logic [CHUNK*DATA_SZ-1:0] pack(input logic [AW-1:0] a);
    logic [CHUNK*DATA_SZ-1:0] r;
    for (int k = 0; k < CHUNK; k++) r[k*DATA_SZ +: DATA_SZ] = mem[int'(a)*CHUNK + k];
    return r;
  endfunction

  // Chunk memory: one-cycle read latency, junk whenever no read was issued.
  always @(posedge clk) begin
    rd_data[0] <= rd_en[0] ? pack(rd_addr[0]) : {$urandom, $urandom};
    rd_data[1] <= rd_en[1] ? pack(rd_addr[1]) : {$urandom, $urandom};
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference: first element of the flat memory holding the extreme value.
  task automatic ref_best(input bit mx, output logic [DATA_SZ-1:0] v, output int pos);
    v = mem[0];
    pos = 0;
    for (int i = 1; i < N; i++) begin
      if (mx ? (mem[i] > v) : (mem[i] < v)) begin
        v = mem[i];
        pos = i;
      end
    end
  endtask

  task automatic fill(input int mode);
    for (int i = 0; i < N; i++) begin
      case (mode)
        1:       mem[i] = 4'hF;
        2:       mem[i] = 4'h9;
        3:       mem[i] = 4'h7;
        4:       mem[i] = DATA_SZ'($urandom_range(0, 2));
        default: mem[i] = DATA_SZ'($urandom_range(0, 15));
      endcase
    end
    if (mode == 1) mem[2*CHUNK + 5] = 4'h3;
    if (mode == 2) begin
      mem[1*CHUNK + 0] = 4'h1;
      mem[3*CHUNK + 7] = 4'h1;
    end
  endtask

  task automatic check_res(input string tag);
    for (int d = 0; d < 2; d++) begin
      chk({tag, d ? "_max_valid" : "_min_valid"}, res_valid[d], 1);
      chk({tag, d ? "_max_value" : "_min_value"}, res_value[d], exp_val[d]);
      chk({tag, d ? "_max_chunk" : "_min_chunk"}, res_chunk[d], exp_pos[d] / CHUNK);
`ifdef EXT_SEARCH_INDEX_EN
      chk({tag, d ? "_max_idx" : "_min_idx"}, res_idx[d], exp_pos[d]);
`endif
    end
  endtask

  // One full search: accept, read sweep, drain, result held for 'hold' cycles
  // with a stray start pulse, then handshake. 'chain' keeps start_valid high.
  task automatic run_search(input int mode, input int hold, input bit chain);
    int w;
    fill(mode);
    ref_best(1'b0, exp_val[0], exp_pos[0]);
    ref_best(1'b1, exp_val[1], exp_pos[1]);
    w = 0;
    while (!(start_ready[0] && start_ready[1]) && w < 20) begin
      @(posedge clk); #1;
      w++;
    end
    chk("start_ready_idle_min", start_ready[0], 1);
    chk("start_ready_idle_max", start_ready[1], 1);
    start_valid = 1'b1;
    @(posedge clk); #1;
    start_valid = 1'b0;
    for (int j = 0; j < CHUNKS; j++) begin
      for (int d = 0; d < 2; d++) begin
        chk("rd_en_read", rd_en[d], 1);
        chk("rd_addr_read", rd_addr[d], j);
        chk("start_ready_busy", start_ready[d], 0);
      end
      @(posedge clk); #1;
    end
    for (int d = 0; d < 2; d++) begin
      chk("rd_en_drain", rd_en[d], 0);
      chk("rd_addr_drain", rd_addr[d], 0);
      chk("res_valid_drain", res_valid[d], 0);
    end
    @(posedge clk); #1;
    check_res("result");
    for (int h = 0; h < hold; h++) begin
      start_valid = (h == 0);
      @(posedge clk); #1;
      start_valid = 1'b0;
      check_res("hold");
      for (int d = 0; d < 2; d++) begin
        chk("start_ready_done", start_ready[d], 0);
        chk("rd_en_done", rd_en[d], 0);
      end
    end
    res_ready = 1'b1;
    if (chain) start_valid = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    for (int d = 0; d < 2; d++) begin
      chk("res_valid_after_hs", res_valid[d], 0);
      chk("start_ready_after_hs", start_ready[d], 1);
      chk("rd_en_after_hs", rd_en[d], 0);
    end
  endtask

  task automatic reset_mid_search();
    fill(0);
    start_valid = 1'b1;
    @(posedge clk); #1;
    start_valid = 1'b0;
    @(posedge clk); #1;
    chk("rd_addr_before_rst", rd_addr[0], 1);
    rst = 1'b1;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("rst_res_valid", res_valid[d], 0);
      chk("rst_rd_en", rd_en[d], 0);
      chk("rst_rd_addr", rd_addr[d], 0);
    end
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    @(posedge clk); #1;
    for (int d = 0; d < 2; d++) begin
      chk("post_rst_start_ready", start_ready[d], 1);
      chk("post_rst_res_valid", res_valid[d], 0);
      chk("post_rst_res_value", res_value[d], 0);
      chk("post_rst_res_chunk", res_chunk[d], 0);
      chk("post_rst_rd_en", rd_en[d], 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    start_valid = 1'b0;
    res_ready = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("reset_rd_en", rd_en[d], 0);
      chk("reset_rd_addr", rd_addr[d], 0);
      chk("reset_res_valid", res_valid[d], 0);
      chk("reset_res_value", res_value[d], 0);
      chk("reset_res_chunk", res_chunk[d], 0);
`ifdef EXT_SEARCH_INDEX_EN
      chk("reset_res_idx", res_idx[d], 0);
`endif
    end
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    @(posedge clk); #1;
    chk("reset_start_ready_min", start_ready[0], 1);
    chk("reset_start_ready_max", start_ready[1], 1);

    run_search(1, 0, 1'b0);   // single low value at chunk 2 lane 5
    run_search(2, 2, 1'b0);   // equal minima: earlier chunk wins
    run_search(3, 5, 1'b0);   // all equal: chunk 0 lane 0
    run_search(4, 1, 1'b1);   // start held through handshake
    run_search(0, 0, 1'b0);   // chained search accepted right after
    reset_mid_search();
    run_search(0, 1, 1'b0);

    for (int r = 0; r < 24; r++) begin
      run_search(($urandom_range(0, 3) == 0) ? 4 : 0,
                 int'($urandom_range(0, 3)),
                 (r < 23) ? 1'($urandom_range(0, 1)) : 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
